// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_pkg
// Description : Shared types and constants for the boot loader slice:
//               FSM state encoding, bytes per word and the checksum seed rule.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_loader_pkg;

    localparam int c_BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CSUM  = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // The running XOR checksum starts from the word-count byte itself.
    function automatic logic [7:0] csum_seed(input logic [7:0] count);
        return count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_if
// Description : Byte-stream handshake plus memory write ports (loader-facing
//               output and CPU-side write port) of the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface boot_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;

    // Loader side
    modport slave (
        input  in_valid, in_data, cpu_we, cpu_addr, cpu_wdata,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    // Byte source / memory / CPU side
    modport master (
        output in_valid, in_data, cpu_we, cpu_addr, cpu_wdata,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/boot_loader_mem_mux.sv
`default_nettype none
// ============================================================================
// Module      : boot_mem_mux
// Description : Memory write-port selector. The loader owns the port until
//               the CPU is released, after which the CPU port passes through.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_mem_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  wire logic              sel,
    input  wire logic              ld_we,
    input  wire logic [ADDR_W-1:0] ld_addr,
    input  wire logic [DATA_W-1:0] ld_wdata,
    input  wire logic              cpu_we,
    input  wire logic [ADDR_W-1:0] cpu_addr,
    input  wire logic [DATA_W-1:0] cpu_wdata,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata
);

    // Loader by default; CPU only once released
    always_comb begin
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        if (sel) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Receives count + big-endian 16-bit words + XOR checksum over a
//               byte valid/ready stream, writes the words to consecutive
//               memory locations and releases the CPU on a good checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 128,
    parameter int BASE_ADDR = 0
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    boot_loader_if.slave bus,
    output logic         cpu_run,
    output logic         done,
    output logic         error
);

    localparam int c_IDX_W = $clog2(MAX_WORDS + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_run;
    logic                r_done;
    logic                r_error;
    logic [c_IDX_W-1:0]  r_idx;
    logic [7:0]          r_count;
    logic [7:0]          r_csum;
    logic [7:0]          r_hi;
    logic                w_hs;
    logic                w_bad_count;
    logic                w_last_word;
    logic [ADDR_W-1:0]   w_word_addr;

    assign w_hs        = bus.in_valid && r_in_ready;
    assign w_bad_count = (bus.in_data == 8'd0) || (int'(bus.in_data) > MAX_WORDS);
    assign w_last_word = !((int'(r_idx) + 1) < int'(r_count));
    // Address wraps modulo 2^ADDR_W if BASE_ADDR is placed too high.
    assign w_word_addr = ADDR_W'(BASE_ADDR + c_BYTES_PER_WORD * int'(r_idx));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; RUN and ERR are terminal until reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_COUNT;
            S_COUNT: if (w_hs) w_state_nxt = w_bad_count ? S_ERR : S_HI;
            S_HI:    if (w_hs) w_state_nxt = S_LO;
            S_LO:    if (w_hs) w_state_nxt = w_last_word ? S_CSUM : S_HI;
            S_CSUM:  if (w_hs) w_state_nxt = (bus.in_data == r_csum) ? S_RUN : S_ERR;
            S_RUN:   w_state_nxt = S_RUN;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: registered status flags, word assembly, checksum and writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_W'(BASE_ADDR);
            r_mem_wdata <= '0;
            r_cpu_run   <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_idx       <= '0;
            r_count     <= '0;
            r_csum      <= '0;
            r_hi        <= '0;
        end else begin
            r_in_ready <= (w_state_nxt == S_COUNT) || (w_state_nxt == S_HI) ||
                          (w_state_nxt == S_LO)    || (w_state_nxt == S_CSUM);
            r_done     <= (w_state_nxt == S_RUN);
            r_cpu_run  <= (w_state_nxt == S_RUN);
            r_error    <= (w_state_nxt == S_ERR);
            r_mem_we   <= 1'b0;
            if (w_hs) begin
                case (r_state)
                    S_COUNT: begin
                        r_count <= bus.in_data;
                        r_csum  <= csum_seed(bus.in_data);
                    end
                    S_HI: begin
                        r_hi   <= bus.in_data;
                        r_csum <= r_csum ^ bus.in_data;
                    end
                    S_LO: begin
                        r_csum      <= r_csum ^ bus.in_data;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_word_addr;
                        r_mem_wdata <= DATA_W'({r_hi, bus.in_data});
                        r_idx       <= r_idx + c_IDX_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign cpu_run      = r_cpu_run;
    assign done         = r_done;
    assign error        = r_error;

    boot_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .sel       (r_cpu_run),
        .ld_we     (r_mem_we),
        .ld_addr   (r_mem_addr),
        .ld_wdata  (r_mem_wdata),
        .cpu_we    (bus.cpu_we),
        .cpu_addr  (bus.cpu_addr),
        .cpu_wdata (bus.cpu_wdata),
        .mem_we    (bus.mem_we),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Directed self-checking bench for boot_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_run;
    logic done;
    logic error;

    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    boot_loader #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .MAX_WORDS (128),
        .BASE_ADDR (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cpu_run (cpu_run),
        .done    (done),
        .error   (error)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] wr_q[$];   // observed writes {addr, data}
    logic [23:0] exp_q[$];  // expected writes {addr, data}
    logic [7:0]  tx_q[$];   // byte stream to send

    // Record each write once per cycle it is high, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, "_cpu_run"},   32'(cpu_run),       32'd0);
        check({tag, "_done"},      32'(done),          32'd0);
        check({tag, "_error"},     32'(error),         32'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        reset_vals(tag);
        tick();
        tick();
        rst_n = 1'b1;
        check({tag, "_ready_low_at_release"}, 32'(bus.in_ready), 32'd0);
        tick();
        check({tag, "_ready_rise"}, 32'(bus.in_ready), 32'd1);
        wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waitc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            tick();
        end
    endtask

    task automatic send_all(input bit gaps);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (gaps) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) check({tag, "_write"}, 32'(wr_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic load_good();
        tx_q  = {8'h03, 8'hF1, 8'h0A, 8'hF2, 8'h02, 8'h73, 8'h12, 8'h69};
        exp_q = {24'h00F10A, 24'h02F202, 24'h047312};
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 8'hAA;
        bus.cpu_wdata = 16'h5555;
        #2;

        // Good load, back-to-back bytes
        apply_reset("por");
        load_good();
        send_all(1'b0);
        check("good_done",     32'(done),         32'd1);
        check("good_cpu_run",  32'(cpu_run),      32'd1);
        check("good_error",    32'(error),        32'd0);
        check("good_in_ready", 32'(bus.in_ready), 32'd0);
        check_writes("good");
        tick();
        check("good_cpu_port_addr", 32'(bus.mem_addr), 32'hAA);
        check("good_cpu_port_we",   32'(bus.mem_we),   32'd0);
        check("good_done_sticky",   32'(done),         32'd1);

        // Bad checksum
        apply_reset("rst_badcs");
        load_good();
        tx_q[7] = 8'h68;
        send_all(1'b0);
        tick();
        check("badcs_error",    32'(error),        32'd1);
        check("badcs_done",     32'(done),         32'd0);
        check("badcs_cpu_run",  32'(cpu_run),      32'd0);
        check("badcs_in_ready", 32'(bus.in_ready), 32'd0);
        check_writes("badcs");

        // Bad count: zero words
        apply_reset("rst_cnt0");
        exp_q.delete();
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("cnt0_error",    32'(error),        32'd1);
        check("cnt0_done",     32'(done),         32'd0);
        check("cnt0_in_ready", 32'(bus.in_ready), 32'd0);
        check_writes("cnt0");

        // Bad count: 129 words
        apply_reset("rst_cnt129");
        send_byte(8'h81);
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("cnt129_error",   32'(error),   32'd1);
        check("cnt129_cpu_run", 32'(cpu_run), 32'd0);
        check_writes("cnt129");

        // Valid toggling every cycle
        apply_reset("rst_gaps");
        load_good();
        send_all(1'b1);
        check("gaps_done",  32'(done),  32'd1);
        check("gaps_error", 32'(error), 32'd0);
        check_writes("gaps");

        // Reset mid-load after byte F2, then a full good load
        apply_reset("rst_mid_pre");
        tx_q = {8'h03, 8'hF1, 8'h0A, 8'hF2};
        send_all(1'b0);
        check("mid_wdata_before_rst", 32'(bus.mem_wdata), 32'h0000F10A);
        rst_n = 1'b0;
        #1;
        reset_vals("midrst");
        apply_reset("rst_mid_post");
        load_good();
        send_all(1'b0);
        check("mid_done", 32'(done), 32'd1);
        check_writes("mid");

        // Maximum size: 128 words, word i = i; XOR of 0..127 is 0 so csum = 0x80
        apply_reset("rst_max");
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(8'h80);
        for (int i = 0; i < 128; i++) begin
            tx_q.push_back(8'h00);
            tx_q.push_back(8'(i));
            exp_q.push_back({8'(2 * i), 16'(i)});
        end
        tx_q.push_back(8'h80);
        send_all(1'b0);
        check("max_done",  32'(done),  32'd1);
        check("max_error", 32'(error), 32'd0);
        check_writes("max");
        if (wr_q.size() == 128) check("max_last_addr", 32'(wr_q[127][23:16]), 32'hFE);
        else check("max_last_addr_present", 32'(wr_q.size()), 32'd128);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
